secure_reg_bank: RTL and testbench

Parametrised bank of NUM_REGS sensitive data registers with privilege- and lock-gated software access. It is the successor to the single sensitive register. Hardware updates occur only on an explicit per-register strobe, never implicitly. Denied accesses are counted and flagged, and a sequential zeroize engine wipes the bank on request. It sits between the system register bus and the security-owning hardware producer.

---
 rtl/secure_reg_pkg.sv | 32 +++
 rtl/viol_counter.sv | 29 ++
 rtl/secure_reg_bank.sv | 191 +++++++++++++++++++
 tb/tb_secure_reg_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_reg_pkg.sv
// Purpose: shared types and access rule for the secure register bank.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package secure_reg_pkg;

    // Zeroize engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WIPE = 2'd1,
        ST_DONE = 2'd2
    } zstate_t;

    // Response data field is sized for the widest supported register; the
    // bank zero-extends its DATA_W-wide read data into it.
    localparam int RESP_DATA_MAX = 64;

    typedef struct packed {
        logic                     rvalid;
        logic                     err;
        logic [RESP_DATA_MAX-1:0] rdata;
    } resp_t;

    // A software access is allowed unless the register is secure and the
    // requester is unprivileged, or it is a write to a locked register.
    function automatic logic access_ok(input logic mask_bit,
                                       input logic priv,
                                       input logic lock,
                                       input logic write);
        return !(mask_bit && !priv) && !(write && lock);
    endfunction

endpackage

// File: rtl/viol_counter.sv
// Purpose: saturating access-violation counter with a one-cycle event pulse.
// Latency: count and pulse update on the edge that samples inc (visible next cycle).
// Backpressure: none; every inc is absorbed, the count sticks at all-ones.
//
// Ports: clk, rst_n (async active-low), inc (violation this cycle),
//        count (saturating total), pulse (registered copy of inc).
module viol_counter #(
    parameter int VCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [VCNT_W-1:0] count,
    output logic              pulse
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= inc;
            if (inc && (count != '1)) begin
                count <= count + VCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/secure_reg_bank.sv
// Purpose: bank of NUM_REGS sensitive registers with privilege/lock-gated bus access and a zeroize engine.
// Latency: every accepted bus request gets its response exactly one cycle later; writes land on the request edge.
// Backpressure: none; one request per cycle is always accepted, refused requests answer with err.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   bus_valid/write/addr/wdata/priv   software request
//   bus_rvalid/rdata/err              registered response
//   hw_we, hw_wdata                   per-register hardware load (slice i = register i)
//   lock_req, lock_q                  sticky software-write locks
//   zeroize_req, zeroize_busy         sequential wipe control/status
//   reg_out                           current register contents
//   viol_count, viol_pulse            violation statistics
module secure_reg_bank
    import secure_reg_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 4,
    parameter int                  ADDR_W      = 2,
    parameter logic [NUM_REGS-1:0] SECURE_MASK = 4'b1100,
    parameter int                  VCNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bus_valid,
    input  logic                         bus_write,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [DATA_W-1:0]            bus_wdata,
    input  logic                         bus_priv,
    output logic                         bus_rvalid,
    output logic [DATA_W-1:0]            bus_rdata,
    output logic                         bus_err,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    input  logic [NUM_REGS-1:0]          lock_req,
    input  logic                         zeroize_req,
    output logic                         zeroize_busy,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          lock_q,
    output logic [VCNT_W-1:0]            viol_count,
    output logic                         viol_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    zstate_t           state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy;
    logic              addr_ok;
    logic [IDX_W-1:0]  addr_idx;
    logic              bus_wr_en;
    logic              viol_inc;
    resp_t             resp_d;
    resp_t             resp_q;

    assign busy         = (state_q != ST_IDLE);
    assign zeroize_busy = busy;

    // Only a bank that does not fill the address space can see out-of-range
    // indices; keeping the compare out of the full case avoids a constant test.
    if (NUM_REGS == (1 << ADDR_W)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_partial
        assign addr_ok = (bus_addr < ADDR_W'(NUM_REGS));
    end

    // Clamp the index so out-of-range addresses never select past the array.
    assign addr_idx = addr_ok ? bus_addr[IDX_W-1:0] : '0;

    // Request decode. Priority: busy / bad address (plain refusal), then
    // access rule (refusal counted as a violation), then hardware collision
    // on a write (plain refusal, hardware value wins).
    always_comb begin
        resp_d    = '0;
        viol_inc  = 1'b0;
        bus_wr_en = 1'b0;
        if (bus_valid) begin
            resp_d.rvalid = 1'b1;
            if (busy || !addr_ok) begin
                resp_d.err = 1'b1;
            end else if (!access_ok(SECURE_MASK[addr_idx], bus_priv,
                                    lock_q[addr_idx], bus_write)) begin
                resp_d.err = 1'b1;
                viol_inc   = 1'b1;
            end else if (bus_write) begin
                if (hw_we[addr_idx]) begin
                    resp_d.err = 1'b1;
                end else begin
                    bus_wr_en = 1'b1;
                end
            end else begin
                resp_d.rdata[DATA_W-1:0] = regs[addr_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign bus_rvalid = resp_q.rvalid;
    assign bus_err    = resp_q.err;
    assign bus_rdata  = resp_q.rdata[DATA_W-1:0];

    if (DATA_W < RESP_DATA_MAX) begin : g_rdata_pad
        logic unused_rdata_hi;
        assign unused_rdata_hi = |resp_q.rdata[RESP_DATA_MAX-1:DATA_W];
    end

    // Register update. While busy the wipe owns the bank: hardware and bus
    // writes are both shut out, and DONE simply holds the cleared values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (busy) begin
                    if ((state_q == ST_WIPE) && (idx_q == IDX_W'(i))) begin
                        regs[i] <= '0;
                    end
                end else if (hw_we[i]) begin
                    regs[i] <= hw_wdata[i*DATA_W +: DATA_W];
                end else if (bus_wr_en && (addr_idx == IDX_W'(i))) begin
                    regs[i] <= bus_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = regs[g];
    end

    // Locks are sticky until reset and survive a wipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_q | lock_req;
        end
    end

    // Zeroize engine: one register per cycle, then a single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (zeroize_req) begin
                        state_q <= ST_WIPE;
                        idx_q   <= '0;
                    end
                end
                ST_WIPE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    viol_counter #(
        .VCNT_W (VCNT_W)
    ) u_viol_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (viol_inc),
        .count (viol_count),
        .pulse (viol_pulse)
    );

endmodule

// File: tb/tb_secure_reg_bank.sv
// Purpose: scoreboard bench for secure_reg_bank (directed vectors, queued expected responses).
// Latency: expects every response exactly one cycle after its request.
// Backpressure: n/a; stimulus issues at most one request per cycle.
module tb_secure_reg_bank;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int VCNT_W   = 8;

    logic                       clk;
    logic                       rst_n;
    logic                       bus_valid;
    logic                       bus_write;
    logic [ADDR_W-1:0]          bus_addr;
    logic [DATA_W-1:0]          bus_wdata;
    logic                       bus_priv;
    logic                       bus_rvalid;
    logic [DATA_W-1:0]          bus_rdata;
    logic                       bus_err;
    logic [NUM_REGS-1:0]        hw_we;
    logic [NUM_REGS*DATA_W-1:0] hw_wdata;
    logic [NUM_REGS-1:0]        lock_req;
    logic                       zeroize_req;
    logic                       zeroize_busy;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [NUM_REGS-1:0]        lock_q;
    logic [VCNT_W-1:0]          viol_count;
    logic                       viol_pulse;

    secure_reg_bank #(
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .SECURE_MASK (4'b1100),
        .VCNT_W      (VCNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_valid    (bus_valid),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_priv     (bus_priv),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err),
        .hw_we        (hw_we),
        .hw_wdata     (hw_wdata),
        .lock_req     (lock_req),
        .zeroize_req  (zeroize_req),
        .zeroize_busy (zeroize_busy),
        .reg_out      (reg_out),
        .lock_q       (lock_q),
        .viol_count   (viol_count),
        .viol_pulse   (viol_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic        viol;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per response and checks timing too.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus_rvalid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_latency", 128'(cyc), 128'(e.cyc + 1));
                check("rsp_err", 128'(bus_err), 128'(e.err));
                check("rsp_rdata", 128'(bus_rdata), 128'(e.rdata));
                check("rsp_viol_pulse", 128'(viol_pulse), 128'(e.viol));
            end else if (bus_rvalid) begin
                check("rsp_unexpected_rvalid", 128'(bus_rvalid), 128'(0));
            end else if (exp_q.size() > 0 && (exp_q[0].cyc + 1) < cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing_rvalid", 128'(bus_rvalid), 128'(1));
            end
        end
    end

    function automatic logic [31:0] slice(input int i);
        return reg_out[i*DATA_W +: DATA_W];
    endfunction

    task automatic push_exp(input logic err, input logic [31:0] rdata, input logic viol);
        exp_t e;
        e.cyc   = cyc;
        e.err   = err;
        e.rdata = rdata;
        e.viol  = viol;
        exp_q.push_back(e);
    endtask

    task automatic set_bus(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd, input logic p);
        bus_valid = 1'b1;
        bus_write = w;
        bus_addr  = a;
        bus_wdata = wd;
        bus_priv  = p;
    endtask

    task automatic req(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       input logic p, input logic e_err, input logic [31:0] e_rd,
                       input logic e_viol);
        @(negedge clk);
        set_bus(w, a, wd, p);
        push_exp(e_err, e_rd, e_viol);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_valid   = 1'b0;
        bus_write   = 1'b0;
        hw_we       = '0;
        lock_req    = '0;
        zeroize_req = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        rst_n       = 1'b0;
        bus_valid   = 1'b0;
        bus_write   = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_priv    = 1'b0;
        hw_we       = '0;
        hw_wdata    = '0;
        lock_req    = '0;
        zeroize_req = 1'b0;

        #12;
        check("rst_reg_out", 128'(reg_out), 128'(0));
        check("rst_lock_q", 128'(lock_q), 128'(0));
        check("rst_viol_count", 128'(viol_count), 128'(0));
        check("rst_rvalid", 128'(bus_rvalid), 128'(0));
        check("rst_err", 128'(bus_err), 128'(0));
        check("rst_rdata", 128'(bus_rdata), 128'(0));
        check("rst_viol_pulse", 128'(viol_pulse), 128'(0));
        check("rst_busy", 128'(zeroize_busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Non-secure register, unprivileged write then read back.
        req(1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        req(1'b0, 2'd1, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
        idle();
        check("reg1_written", 128'(slice(1)), 128'(32'hDEADBEEF));

        // Secure register: privileged write, unprivileged read refused, privileged read ok.
        req(1'b1, 2'd3, 32'h33333333, 1'b1, 1'b0, 32'h0, 1'b0);
        req(1'b0, 2'd3, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        idle();
        check("viol_count_1", 128'(viol_count), 128'(1));
        req(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, 32'h33333333, 1'b0);
        req(1'b1, 2'd3, 32'h00000BAD, 1'b0, 1'b1, 32'h0, 1'b1);
        idle();
        check("viol_count_2", 128'(viol_count), 128'(2));
        check("reg3_kept", 128'(slice(3)), 128'(32'h33333333));

        // Lock register 2: privileged write refused, hardware update still lands.
        @(negedge clk);
        lock_req = 4'b0100;
        idle();
        check("lock_q_set", 128'(lock_q), 128'(4'b0100));
        req(1'b1, 2'd2, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b1);
        idle();
        check("viol_count_3", 128'(viol_count), 128'(3));
        check("reg2_locked", 128'(slice(2)), 128'(0));
        @(negedge clk);
        hw_we = 4'b0100;
        hw_wdata[2*DATA_W +: DATA_W] = 32'hA5A5A5A5;
        idle();
        check("reg2_hw", 128'(slice(2)), 128'(32'hA5A5A5A5));
        req(1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0);
        idle();

        // Same-cycle hardware load and bus write: hardware wins, not a violation.
        @(negedge clk);
        hw_we = 4'b0001;
        hw_wdata[0 +: DATA_W] = 32'h00001111;
        set_bus(1'b1, 2'd0, 32'h00002222, 1'b0);
        push_exp(1'b1, 32'h0, 1'b0);
        idle();
        check("reg0_hw_wins", 128'(slice(0)), 128'(32'h00001111));
        check("viol_count_hw", 128'(viol_count), 128'(3));

        // Fill and wipe.
        req(1'b1, 2'd0, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b0);
        req(1'b1, 2'd1, 32'h00000002, 1'b0, 1'b0, 32'h0, 1'b0);
        req(1'b1, 2'd3, 32'h00000004, 1'b1, 1'b0, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        zeroize_req = 1'b1;
        busy_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            zeroize_req = 1'b0;
            bus_valid   = 1'b0;
            hw_we       = '0;
            if (zeroize_busy) busy_cnt++;
            if (i == 1) begin
                set_bus(1'b0, 2'd1, 32'h0, 1'b1);
                push_exp(1'b1, 32'h0, 1'b0);
            end
            if (i == 2) begin
                hw_we = 4'b0001;
                hw_wdata[0 +: DATA_W] = 32'hFFFFFFFF;
            end
        end
        check("busy_cycles", 128'(busy_cnt), 128'(5));
        check("wipe_regs", 128'(reg_out), 128'(0));
        check("wipe_lock_kept", 128'(lock_q), 128'(4'b0100));
        check("wipe_count_kept", 128'(viol_count), 128'(3));

        // 260 more violations: counter must stick at 255.
        for (int i = 0; i < 260; i++) begin
            req(1'b0, 2'd3, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        end
        idle();
        check("viol_saturate", 128'(viol_count), 128'(255));

        // Reset in the middle of a wipe.
        req(1'b1, 2'd1, 32'h00000077, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        zeroize_req = 1'b1;
        @(negedge clk);
        zeroize_req = 1'b0;
        @(negedge clk);
        check("mid_wipe_busy", 128'(zeroize_busy), 128'(1));
        check("mid_wipe_reg1", 128'(slice(1)), 128'(32'h00000077));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_reg_out", 128'(reg_out), 128'(0));
        check("arst_lock_q", 128'(lock_q), 128'(0));
        check("arst_viol_count", 128'(viol_count), 128'(0));
        check("arst_busy", 128'(zeroize_busy), 128'(0));
        check("arst_rvalid", 128'(bus_rvalid), 128'(0));
        check("arst_err", 128'(bus_err), 128'(0));
        check("arst_rdata", 128'(bus_rdata), 128'(0));
        check("arst_viol_pulse", 128'(viol_pulse), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Lock cleared by reset: register 2 writable again.
        req(1'b1, 2'd2, 32'h00000005, 1'b1, 1'b0, 32'h0, 1'b0);
        req(1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h00000005, 1'b0);
        idle();
        idle();
        idle();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
